pulse_burst_sched: RTL and testbench

//   Sequences the pulse-generation datapath: on a start request, emits a burst of
//   num_i single-cycle pulses spaced period_i clocks apart, then signals done.

---
 rtl/pulse_pkg.sv | 18 +
 rtl/pulse_burst_sched_if.sv | 43 ++++
 rtl/pulse_tick_counter.sv | 35 +++
 rtl/pulse_burst_sched.sv | 118 +++++++++++
 tb/tb_pulse_burst_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse burst scheduler.
// State encoding is fixed here so other pulse blocks can reuse it.
package pulse_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int NUM_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/pulse_burst_sched_if.sv
// Control/status bundle between a CSR master and the burst scheduler.
// repeat_i exists only when PULSE_BURST_REPEAT_EN is defined.
interface pulse_burst_sched_if
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) ();

    logic             start_i;
    logic [CNT_W-1:0] period_i;
    logic [NUM_W-1:0] num_i;
    logic             abort_i;
`ifdef PULSE_BURST_REPEAT_EN
    logic             repeat_i;
`endif
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic             pulse_o;
    logic [NUM_W-1:0] pulse_idx_o;

`ifdef PULSE_BURST_REPEAT_EN
    modport master (
        output start_i, period_i, num_i, abort_i, repeat_i,
        input  busy_o, done_o, err_o, pulse_o, pulse_idx_o
    );
    modport slave (
        input  start_i, period_i, num_i, abort_i, repeat_i,
        output busy_o, done_o, err_o, pulse_o, pulse_idx_o
    );
`else
    modport master (
        output start_i, period_i, num_i, abort_i,
        input  busy_o, done_o, err_o, pulse_o, pulse_idx_o
    );
    modport slave (
        input  start_i, period_i, num_i, abort_i,
        output busy_o, done_o, err_o, pulse_o, pulse_idx_o
    );
`endif

endinterface

// File: rtl/pulse_tick_counter.sv
// Loadable period counter: counts 0..P-1 while enabled.
// tick is high when the count sits at P-1 (wrap point).
module pulse_tick_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    input  logic             clr,
    input  logic             en,
    output logic             tick
);

    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == per_q - CNT_W'(1));

    // Latch the period on load, otherwise count and wrap at P-1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            per_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            per_q <= period;
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pulse_burst_sched.sv
// Burst scheduler: N pulses spaced P clocks apart, then done.
// Build with PULSE_BURST_REPEAT_EN for back-to-back repeating bursts.
module pulse_burst_sched
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input logic               clk,
    input logic               rstn,
    pulse_burst_sched_if.slave bus
);

    state_t           state_q, state_d;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] idx_q;
    logic             busy_q, done_q, err_q, pulse_q;
    logic             rep_last_q;
    logic             rep_q;
    logic             tick;
    logic             valid;
    logic             accept, reject, adv, last, abort_run;

    assign valid = (bus.period_i != '0) && (bus.num_i != '0);

    pulse_tick_counter #(.CNT_W(CNT_W)) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .load   (accept),
        .period (bus.period_i),
        .clr    (abort_run),
        .en     (state_q == RUN),
        .tick   (tick)
    );

    // Next state plus per-edge events (accept, reject, pulse, last).
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        adv       = 1'b0;
        last      = 1'b0;
        abort_run = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    if (valid) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    abort_run = 1'b1;
                    state_d   = IDLE;
                end else if (tick) begin
                    adv = 1'b1;
                    if (idx_q == num_q - NUM_W'(1)) begin
                        last    = 1'b1;
                        state_d = rep_q ? RUN : DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs and pulse index.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            num_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pulse_q    <= 1'b0;
            rep_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_q == RUN) && !bus.abort_i;
            done_q     <= (state_q == DONE) || rep_last_q;
            err_q      <= reject;
            pulse_q    <= adv;
            rep_last_q <= last && rep_q;
            if (accept) begin
                num_q <= bus.num_i;
                idx_q <= '0;
            end else if (adv) begin
                idx_q <= (last && rep_q) ? '0 : idx_q + NUM_W'(1);
            end
        end
    end

`ifdef PULSE_BURST_REPEAT_EN
    // Repeat mode is chosen once per start.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rep_q <= 1'b0;
        end else if (accept) begin
            rep_q <= bus.repeat_i;
        end
    end
`else
    assign rep_q = 1'b0;
`endif

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.pulse_o     = pulse_q;
    assign bus.pulse_idx_o = idx_q;

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Testbench for pulse_burst_sched: vector table, corner sequences,
// and randomized traffic against a schedule-based reference model.
module tb_pulse_burst_sched;

    logic clk;
    logic rstn;
    int   n_chk  = 0;
    int   n_pass = 0;

    pulse_burst_sched_if #(.CNT_W(8), .NUM_W(8)) bus ();

    pulse_burst_sched dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int period;
        int num;
        int abort_at;
        int exp_pulses;
        int exp_first;
        int exp_done;
        int exp_idx;
        int exp_err;
        int exp_busy;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    function automatic int outs();
        logic [11:0] v;
        v = {bus.busy_o, bus.done_o, bus.err_o, bus.pulse_o,
             bus.pulse_idx_o};
        return int'(v);
    endfunction

    task automatic idle_in();
        bus.start_i  = 1'b0;
        bus.abort_i  = 1'b0;
        bus.period_i = '0;
        bus.num_i    = '0;
`ifdef PULSE_BURST_REPEAT_EN
        bus.repeat_i = 1'b0;
`endif
    endtask

    task automatic do_reset();
        idle_in();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Start sampled at "edge 0"; returns just after that edge.
    task automatic launch(input int p, input int n);
        bus.start_i  = 1'b1;
        bus.period_i = 8'(p);
        bus.num_i    = 8'(n);
        step();
        bus.start_i  = 1'b0;
    endtask

    task automatic observe(input int w, input int ab_at,
                           output int np, output int first,
                           output int dn, output int ne,
                           output int nb);
        np = 0; first = -1; dn = -1; ne = 0; nb = 0;
        for (int c = 0; c <= w; c++) begin
            if (bus.pulse_o) begin
                np++;
                if (first < 0) first = c;
            end
            if (bus.done_o && dn < 0) dn = c;
            if (bus.err_o) ne++;
            if (bus.busy_o) nb++;
            bus.abort_i = (c == ab_at);
            step();
        end
        bus.abort_i = 1'b0;
    endtask

    task automatic rand_test(input int ncyc);
        int e0, mp, mn, held, d, p, n, exp;
        bit ab, st, abt, in_run, idle, err_e;
        bit ebusy, edone, epulse;
        int eidx;
        e0 = -1; mp = 0; mn = 0; held = 0; ab = 1'b0;
        do_reset();
        for (int e = 1; e <= ncyc; e++) begin
            st  = ($urandom % 5) == 0;
            abt = ($urandom % 25) == 0;
            p = (($urandom % 8) == 0) ? 0 : 1 + int'($urandom % 5);
            n = (($urandom % 8) == 0) ? 0 : 1 + int'($urandom % 4);
            bus.start_i  = st;
            bus.abort_i  = abt;
            bus.period_i = 8'(p);
            bus.num_i    = 8'(n);
            step();
            in_run = e0 >= 0 && !ab && e > e0 && e <= e0 + mn * mp;
            idle = !in_run &&
                   !(e0 >= 0 && !ab && e == e0 + mn * mp + 1);
            err_e = 1'b0;
            if (idle && st && !abt) begin
                if (p != 0 && n != 0) begin
                    e0 = e; mp = p; mn = n; ab = 1'b0;
                end else begin
                    err_e = 1'b1;
                end
            end else if (in_run && abt) begin
                ab   = 1'b1;
                held = (e - 1 - e0) / mp;
            end
            ebusy = 0; edone = 0; epulse = 0; eidx = held;
            if (e0 >= 0 && !ab) begin
                d = e - e0;
                if (d == 0) begin
                    eidx = 0;
                end else if (d <= mn * mp) begin
                    ebusy  = 1;
                    epulse = (d % mp) == 0;
                    eidx   = d / mp;
                end else begin
                    edone = (d == mn * mp + 1);
                    eidx  = mn;
                end
            end
            exp = int'({ebusy, edone, err_e, epulse, 8'(eidx)});
            chk($sformatf("rand_e%0d", e), outs(), exp);
        end
        idle_in();
    endtask

    vec_t vt[9];
    int   np, first, dn, ne, nb;

    initial begin
        rstn = 1'b0;
        idle_in();

        vt[0] = '{4,   3, -1, 3, 4,   13,  3, 0, 12};
        vt[1] = '{1,   5, -1, 5, 1,   6,   5, 0, 5};
        vt[2] = '{0,   3, -1, 0, -1,  -1,  0, 1, 0};
        vt[3] = '{3,   0, -1, 0, -1,  -1,  0, 1, 0};
        vt[4] = '{4,   8,  8, 2, 4,   -1,  2, 0, 8};
        vt[5] = '{2,   3, -1, 3, 2,   7,   3, 0, 6};
        vt[6] = '{255, 1, -1, 1, 255, 256, 1, 0, 255};
        vt[7] = '{3,   2,  5, 1, 3,   -1,  1, 0, 5};
        vt[8] = '{1,   1, -1, 1, 1,   2,   1, 0, 1};

        do_reset();
        chk("reset_outs", outs(), 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            launch(vt[i].period, vt[i].num);
            observe(300, vt[i].abort_at, np, first, dn, ne, nb);
            chk($sformatf("v%0d_pulses", i), np, vt[i].exp_pulses);
            chk($sformatf("v%0d_first", i), first, vt[i].exp_first);
            chk($sformatf("v%0d_done", i), dn, vt[i].exp_done);
            chk($sformatf("v%0d_idx", i),
                int'(bus.pulse_idx_o), vt[i].exp_idx);
            chk($sformatf("v%0d_err", i), ne, vt[i].exp_err);
            chk($sformatf("v%0d_busy", i), nb, vt[i].exp_busy);
        end

        // Start pulsed mid-burst with other values is ignored.
        do_reset();
        launch(4, 3);
        np = 0; dn = -1; ne = 0;
        for (int c = 0; c <= 20; c++) begin
            if (bus.pulse_o) np++;
            if (bus.done_o && dn < 0) dn = c;
            if (bus.err_o) ne++;
            bus.start_i  = (c == 5);
            bus.period_i = (c == 5) ? 8'd1 : 8'd0;
            bus.num_i    = (c == 5) ? 8'd1 : 8'd0;
            step();
        end
        idle_in();
        chk("ign_pulses", np, 3);
        chk("ign_done", dn, 13);
        chk("ign_err", ne, 0);

        // Abort and start together in IDLE: nothing starts.
        do_reset();
        bus.start_i  = 1'b1;
        bus.abort_i  = 1'b1;
        bus.period_i = 8'd4;
        bus.num_i    = 8'd3;
        step();
        chk("abst_err", int'(bus.err_o), 0);
        idle_in();
        step();
        chk("abst_busy1", int'(bus.busy_o), 0);
        step();
        chk("abst_busy2", int'(bus.busy_o), 0);

        // Reset mid-burst clears everything, no done afterwards.
        do_reset();
        launch(2, 5);
        for (int c = 0; c < 4; c++) step();
        chk("rst_mid_pulse", int'(bus.pulse_o), 1);
        rstn = 1'b0;
        step();
        chk("rst_mid_outs", outs(), 0);
        rstn = 1'b1;
        observe(12, -1, np, first, dn, ne, nb);
        chk("rst_mid_done", dn, -1);
        chk("rst_mid_busy", nb, 0);

        // Abort after 2nd pulse, then a fresh start works.
        do_reset();
        launch(4, 8);
        observe(12, 8, np, first, dn, ne, nb);
        chk("reab_idx", int'(bus.pulse_idx_o), 2);
        launch(1, 2);
        chk("reab_idx0", int'(bus.pulse_idx_o), 0);
        observe(6, -1, np, first, dn, ne, nb);
        chk("reab_pulses", np, 2);
        chk("reab_done", dn, 3);

`ifdef PULSE_BURST_REPEAT_EN
        // Repeating P=2 N=2: done every 4 cycles, busy stays high.
        do_reset();
        bus.repeat_i = 1'b1;
        launch(2, 2);
        bus.repeat_i = 1'b0;
        ne = 0; nb = 0; dn = 0;
        for (int c = 0; c <= 16; c++) begin
            if (bus.done_o) begin
                dn++;
                if (!(c >= 5 && (c % 4) == 1)) ne++;
            end
            if (c >= 1 && !bus.busy_o) nb++;
            bus.abort_i = (c == 16);
            step();
        end
        bus.abort_i = 1'b0;
        chk("rep_done_cnt", dn, 3);
        chk("rep_done_pos", ne, 0);
        chk("rep_busy_gap", nb, 0);
        chk("rep_abort_busy", int'(bus.busy_o), 0);
        step();
        chk("rep_abort_done", int'(bus.done_o), 0);
`endif

        rand_test(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
